// File: rtl/eqv_stim_checker.sv
// eqv_stim_checker: LFSR stimulus source plus o1/o2 equivalence monitor.
// Counts mismatches and captures the first failing vector and its index.
module eqv_stim_checker #(
  parameter logic [5:0] SEED  = 6'h01,
  parameter int         LAT   = 1,
  parameter int         CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vec_i,
  output logic [5:0]       vec_o,
  input  logic             o1_i,
  input  logic             o2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [5:0]       ff_vec_o,
  output logic [CNT_W-1:0] ff_idx_o
);

  localparam logic [5:0] SEED_EFF = (SEED == 6'h00) ? 6'h01 : SEED;
  localparam int         PW       = 7 + CNT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [5:0]       ffv_q, ffv_d;
  logic [2:0]       drn_q, drn_d;

  logic [PW-1:0]    cur;
  logic             cmp_v;
  logic [5:0]       cmp_vec;
  logic [CNT_W-1:0] cmp_idx;
  logic             mism;

  assign vec_o = (state_q == S_RUN) ? lfsr_q : 6'h00;
  assign cur   = {state_q == S_RUN, vec_o, idx_q};

  generate
    if (LAT == 0) begin : g_nodly
      assign {cmp_v, cmp_vec, cmp_idx} = cur;
    end else begin : g_dly
      logic [LAT-1:0][PW-1:0] pipe_q, pipe_d;

      // shift {valid, vec, idx} forward to line up with o1/o2
      always_comb begin
        pipe_d[0] = cur;
        for (int i = 1; i < LAT; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      // delay line register, cleared on reset
      always_ff @(posedge clk_i) begin
        if (!rst_i) pipe_q <= '0;
        else        pipe_q <= pipe_d;
      end

      assign {cmp_v, cmp_vec, cmp_idx} = pipe_q[LAT-1];
    end
  endgenerate

  assign mism = cmp_v && (o1_i != o2_i);

  // next-state, stimulus advance and mismatch bookkeeping
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    num_d   = num_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    drn_d   = drn_q;
    if (mism) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) begin
        ffv_d = cmp_vec;
        ffi_d = cmp_idx;
      end
    end
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          num_d   = num_vec_i;
          lfsr_d  = SEED_EFF;
          idx_d   = '0;
          err_d   = '0;
          ffv_d   = '0;
          ffi_d   = '0;
          state_d = (num_vec_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
        idx_d  = idx_q + 1'b1;
        if (idx_q == num_q - 1'b1) begin
          drn_d   = '0;
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drn_q == 3'(LAT - 1)) state_d = S_DONE;
        else                      drn_d   = drn_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      idx_q   <= '0;
      num_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      drn_q   <= drn_d;
    end
  end

  assign busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o    = (state_q == S_DONE);
  assign pass_o    = (state_q == S_DONE) && (err_q == '0);
  assign err_cnt_o = err_q;
  assign ff_vec_o  = ffv_q;
  assign ff_idx_o  = ffi_q;

endmodule

// File: tb/tb_eqv_stim_checker.sv
// tb_eqv_stim_checker: random runs against a queue-based result model.
// A fake circuit under test flips o2 on chosen vector indices.
module tb_eqv_stim_checker;

  localparam int LAT = 1;

  typedef struct {
    int         s;
    int         n;
    int         err;
    logic [5:0] fv;
    int         fi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] num_vec_i = '0;
  logic [5:0]  vec_o;
  logic        o1_i, o2_i;
  logic        busy_o, done_o, pass_o;
  logic [15:0] err_cnt_o, ff_idx_o;
  logic [5:0]  ff_vec_o;

  eqv_stim_checker #(
    .SEED (6'h01),
    .LAT  (LAT),
    .CNT_W(16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .num_vec_i(num_vec_i),
    .vec_o    (vec_o),
    .o1_i     (o1_i),
    .o2_i     (o2_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .pass_o   (pass_o),
    .err_cnt_o(err_cnt_o),
    .ff_vec_o (ff_vec_o),
    .ff_idx_o (ff_idx_o)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;
  int busy_cnt = 0;
  exp_t rq[$];
  logic [5:0] vq[$];
  bit inj[256];

  initial forever @(posedge clk) cyc <= cyc + 1;

  // circuit under test: one-cycle latency, o2 flipped on injected indices
  logic [5:0] vd = '0;
  logic       pres_d = 1'b0;
  int         k = 0;
  int         kd = 0;

  initial forever @(posedge clk) begin
    vd     <= vec_o;
    pres_d <= (vec_o != 6'h00);
    kd     <= k;
    if (rst_i && start_i && !busy_o) k <= 0;
    else if (vec_o != 6'h00)         k <= k + 1;
  end

  assign o1_i = ^vd;
  assign o2_i = o1_i ^ (pres_d && inj[kd % 256]);

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    nchk++;
    $display("FAIL %s: got timeout expected completion", nm);
  endtask

  function automatic logic [5:0] ref_vec(input int idx);
    logic [5:0] v;
    v = 6'h01;
    for (int i = 0; i < idx % 63; i++) v = {v[4:0], v[5] ^ v[4]};
    return v;
  endfunction

  task automatic issue(input int n);
    exp_t e;
    @(posedge clk);
    #1;
    start_i   = 1'b1;
    num_vec_i = 16'(n);
    e.s   = cyc + 1;
    e.n   = n;
    e.err = 0;
    e.fv  = '0;
    e.fi  = 0;
    for (int i = 0; i < n; i++) begin
      vq.push_back(ref_vec(i));
      if (inj[i % 256]) begin
        if (e.err == 0) begin
          e.fv = ref_vec(i);
          e.fi = i;
        end
        if (e.err < 65535) e.err++;
      end
    end
    rq.push_back(e);
    busy_cnt = 0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < n + 40 && rq.size() > 0; i++) @(negedge clk);
    if (rq.size() > 0) begin
      fail("run_done");
      rq.delete();
    end
    chk("vec_left", vq.size(), 0);
    vq.delete();
  endtask

  task automatic set_inj(input int mode, input int idx);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       inj[i] = 1'b0;
        1:       inj[i] = (i == idx);
        2:       inj[i] = 1'b1;
        default: inj[i] = ($urandom_range(0, 7) == 0);
      endcase
    end
  endtask

  // monitor: checks every presented vector and every finished run
  initial forever @(negedge clk) begin
    exp_t e;
    logic [5:0] ev;
    if (vec_o != 6'h00) begin
      if (vq.size() == 0) begin
        chk("vec_extra", int'(vec_o), 0);
      end else begin
        ev = vq.pop_front();
        chk("vec", int'(vec_o), int'(ev));
      end
    end
    if (busy_o) busy_cnt++;
    if (rq.size() > 0 && cyc >= rq[0].s && done_o) begin
      e = rq.pop_front();
      chk("done_lat", cyc - e.s, (e.n == 0) ? 0 : e.n + LAT);
      chk("busy_cyc", busy_cnt, (e.n == 0) ? 0 : e.n + LAT);
      chk("err_cnt", int'(err_cnt_o), e.err);
      chk("ff_vec", int'(ff_vec_o), int'(e.fv));
      chk("ff_idx", int'(ff_idx_o), e.fi);
      chk("pass", int'(pass_o), int'(e.err == 0));
    end
  end

  initial begin
    bit hit;
    set_inj(0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_vec", int'(vec_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_pass", int'(pass_o), 0);
    chk("rst_err", int'(err_cnt_o), 0);
    chk("rst_ffv", int'(ff_vec_o), 0);
    chk("rst_ffi", int'(ff_idx_o), 0);

    set_inj(0, 0);
    issue(6);
    wait_done(6);

    set_inj(1, 4);
    issue(6);
    wait_done(6);

    set_inj(2, 0);
    issue(64);
    wait_done(64);

    set_inj(0, 0);
    issue(0);
    wait_done(0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 150);
      set_inj(3, 0);
      issue(n);
      wait_done(n);
    end

    set_inj(0, 0);
    issue(10);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (vec_o == ref_vec(3)) hit = 1'b1;
    end
    chk("abort_hit", int'(hit), 1);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    chk("abort_vec", int'(vec_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_pass", int'(pass_o), 0);
    vq.delete();
    rq.delete();
    issue(5);
    wait_done(5);

    issue(20);
    repeat (5) @(posedge clk);
    #1;
    start_i   = 1'b1;
    num_vec_i = 16'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(20);

    set_inj(2, 0);
    issue(3);
    wait_done(3);
    set_inj(0, 0);
    issue(4);
    @(negedge clk);
    chk("restart_err", int'(err_cnt_o), 0);
    chk("restart_ffv", int'(ff_vec_o), 0);
    chk("restart_busy", int'(busy_o), 1);
    wait_done(4);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
